shift16_right_seq: RTL and testbench
====================================

// Module: shift16_right_seq
// PURPOSE
//   Iterative 16-bit right shifter: the right-shift counterpart of the left shifter, which
//   multiplies by 2**distance. Shifts one bit position per clock under a start/busy/done
//   handshake and supports logical or arithmetic (sign-filling) right shifts.
//   Serves the ALU's SRL/SRA paths where a full barrel shifter or divider is not wanted.
// PARAMETERS
//   WIDTH   16  data width of a and r
//   DIST_W  5   width of distance; values >= WIDTH are legal (see saturation rule)
// PORTS
//   clk       in   1        rising-edge clock
//   rst       in   1        asynchronous, active-high reset
//   start     in   1        request a shift; sampled only when the block is not busy
//   a         in   WIDTH    operand, captured on the accepted start edge
//   distance  in   DIST_W   shift amount, captured on the accepted start edge
//   arith     in   1        1 = arithmetic (fill with a[WIDTH-1]), 0 = logical (fill with 0)
//   busy      out  1        high while a shift is in progress
//   done      out  1        single-cycle pulse: r is valid and updated
//   r         out  WIDTH    result; holds its value until the next done
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, r=0, busy=0, done=0, internal count=0. No output
//     glitches to nonzero values while rst is high.
//   FSM: IDLE, SHIFT, DONE. All outputs are registered.
//   - IDLE/DONE + start=1 at edge N: capture a, arith, sign=a[WIDTH-1];
//     k = min(distance, WIDTH); cnt <= k; state <= SHIFT; busy <= 1.
//   - SHIFT, cnt != 0: work <= {fill, work[WIDTH-1:1]}, where fill = arith ? sign : 0;
//     cnt <= cnt - 1.
//   - SHIFT, cnt == 0: r <= work; done <= 1; busy <= 0; state <= DONE.
//   - DONE: done stays high for this one cycle only; returns to IDLE unless start=1, in which
//     case the new request is accepted (back-to-back, no dead cycle).
//   Latency: start accepted at edge N gives done high in the cycle following edge N+k+1.
//     Throughput is one result per k+2 cycles.
//   Saturation: distance >= WIDTH is treated as WIDTH, so the logical result is 0 and the
//     arithmetic result is all sign bits. Latency is WIDTH+1 (17 for WIDTH=16).
//   distance = 0: r = a; done follows 1 edge after the accepting edge.
//   start while busy: ignored; the in-flight a, distance and arith are unaffected.
//   Input changes while busy: no effect, because all operands are captured at start.
//   rst mid-shift: the shift is aborted and no done is emitted; r returns to 0.
//   r changes only on the edge that raises done (or on reset).
// TESTING
//   1. Assert rst mid-cycle (asynchronous) -> r=0, busy=0, done=0 immediately.
//      Release rst -> state IDLE.
//   2. a=16'hF0F0, distance=4, arith=0, start pulse -> busy for 5 cycles;
//      done one cycle with r=16'h0F0F.
//   3. a=16'h8000, distance=15: arith=1 -> r=16'hFFFF; arith=0 -> r=16'h0001;
//      done 16 edges after the accept edge.
//   4. a=16'h1234, distance=0 -> r=16'h1234, done on the cycle after the accept edge.
//   5. a=16'h8001, distance=20: arith=1 -> r=16'hFFFF; arith=0 -> r=16'h0000;
//      latency 17 in both cases.
//   6. Hold start=1 continuously (a=16'h00F0, d=4, then a=16'h0F00, d=8): the second request
//      is taken in the DONE cycle -> r=16'h000F then 16'h000F; changes to start, a and
//      distance while busy are ignored.
//      Assert rst during SHIFT -> no done pulse; a subsequent fresh start operates normally.
//   Compare r against a behavioural model ($signed(a) >>> d or a >> d) over 1000 random
//     (a, distance 0..31, arith) triples.

Source files
------------

// File: rtl/shift16_right_seq.sv
// shift16_right_seq: iterative right shifter, one bit position per clock.
// Logical or arithmetic fill; distances of WIDTH or more saturate to WIDTH.
module shift16_right_seq #(
    parameter int WIDTH  = 16,
    parameter int DIST_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [DIST_W-1:0] distance,
    input  logic              arith,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  r
);

    localparam logic [DIST_W-1:0] LP_MAX = DIST_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_work;
    logic [DIST_W-1:0] r_cnt;
    logic              r_fill;
    logic [DIST_W-1:0] w_k;

    // Shifting WIDTH places already yields all-fill, so larger counts are wasted cycles
    assign w_k = (distance >= LP_MAX) ? LP_MAX : distance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_fill  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            r       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_work  <= a;
                        r_fill  <= arith & a[WIDTH-1];
                        r_cnt   <= w_k;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_work <= {r_fill, r_work[WIDTH-1:1]};
                        r_cnt  <= r_cnt - DIST_W'(1);
                    end else begin
                        r       <= r_work;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift16_right_seq.sv
// tb_shift16_right_seq: directed and randomized checks of the iterative
// right shifter against an arithmetic reference model.
module tb_shift16_right_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [4:0]  distance = '0;
    logic        arith = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] r;

    int total = 0;
    int bad = 0;

    shift16_right_seq dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .distance(distance),
        .arith(arith),
        .busy(busy),
        .done(done),
        .r(r)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] va,
                                          input int vd,
                                          input logic varith);
        logic signed [15:0] s;
        s = va;
        if (varith) return 16'(s >>> vd);
        return va >> vd;
    endfunction

    function automatic int exp_lat(input int vd);
        return ((vd >= 16) ? 16 : vd) + 1;
    endfunction

    // Drives one request; reports result, edges from accept to done,
    // busy cycles, whether r moved early, and done one edge later.
    task automatic run_op(input logic [15:0] ta, input logic [4:0] td,
                          input logic tarith, input bit scramble,
                          output logic [15:0] res, output int lat,
                          output int bcnt, output bit early,
                          output logic dnext);
        logic [15:0] rprev;
        @(negedge clk);
        a = ta;
        distance = td;
        arith = tarith;
        start = 1'b1;
        rprev = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        bcnt = (busy === 1'b1) ? 1 : 0;
        early = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            if (scramble) begin
                start = 1'($urandom);
                a = 16'($urandom);
                distance = 5'($urandom);
                arith = 1'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1) bcnt++;
            if (done !== 1'b1 && r !== rprev) early = 1'b1;
        end
        start = 1'b0;
        res = r;
        @(posedge clk);
        #1;
        dnext = done;
    endtask

    task automatic test_reset();
        logic [15:0] res;
        int lat, bcnt;
        bit early;
        logic dn;
        #1 rst = 1'b1;
        #2;
        total++;
        if ({r, busy, done} !== 18'd0) begin
            bad++;
            $display("FAIL reset_init r=%h busy=%b done=%b want 0", r, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(16'hABCD, 5'd1, 1'b0, 1'b0, res, lat, bcnt, early, dn);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if ({r, busy, done} !== 18'd0) begin
            bad++;
            $display("FAIL reset_async r=%h busy=%b done=%b want 0", r, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] res;
        int lat, bcnt;
        bit early;
        logic dn;
        run_op(16'hF0F0, 5'd4, 1'b0, 1'b0, res, lat, bcnt, early, dn);
        total++;
        if (res !== 16'h0F0F) begin
            bad++;
            $display("FAIL basic_r got=%h want=0f0f", res);
        end
        total++;
        if (bcnt !== 5) begin
            bad++;
            $display("FAIL basic_busy got=%0d want=5", bcnt);
        end
        total++;
        if (lat !== 5) begin
            bad++;
            $display("FAIL basic_lat got=%0d want=5", lat);
        end
        total++;
        if (dn !== 1'b0) begin
            bad++;
            $display("FAIL basic_pulse done_next=%b want 0", dn);
        end
    endtask

    task automatic test_edges();
        logic [15:0] res;
        int lat, bcnt;
        bit early;
        logic dn;
        logic [15:0] ta [6] = '{16'h8000, 16'h8000, 16'h1234,
                                16'h8001, 16'h8001, 16'h7FFF};
        logic [4:0] td [6] = '{5'd15, 5'd15, 5'd0, 5'd20, 5'd20, 5'd31};
        logic tr [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] want [6] = '{16'hFFFF, 16'h0001, 16'h1234,
                                  16'hFFFF, 16'h0000, 16'h0000};
        int wlat [6] = '{16, 16, 1, 17, 17, 17};
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], td[i], tr[i], 1'b0, res, lat, bcnt, early, dn);
            total++;
            if (res !== want[i]) begin
                bad++;
                $display("FAIL edge%0d_r got=%h want=%h", i, res, want[i]);
            end
            total++;
            if (lat !== wlat[i]) begin
                bad++;
                $display("FAIL edge%0d_lat got=%0d want=%0d", i, lat, wlat[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        a = 16'h00F0;
        distance = 5'd4;
        arith = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h0F00;
        distance = 5'd8;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n !== 5 || r !== 16'h000F) begin
            bad++;
            $display("FAIL b2b_first r=%h lat=%0d want 000f lat 5", r, n);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept busy=%b done=%b want 1 0", busy, done);
        end
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n !== 10 || r !== 16'h000F) begin
            bad++;
            $display("FAIL b2b_second r=%h lat=%0d want 000f lat 10", r, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rst_mid();
        logic [15:0] res;
        int lat, bcnt;
        bit early;
        logic dn;
        int seen;
        @(negedge clk);
        a = 16'hC3C3;
        distance = 5'd10;
        arith = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({r, busy, done} !== 18'd0) begin
            bad++;
            $display("FAIL rst_mid r=%h busy=%b done=%b want 0", r, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL rst_mid_nodone pulses=%0d want 0", seen);
        end
        run_op(16'h9000, 5'd3, 1'b1, 1'b0, res, lat, bcnt, early, dn);
        total++;
        if (res !== 16'hF200 || lat !== 4) begin
            bad++;
            $display("FAIL rst_mid_after r=%h lat=%0d want f200 lat 4", res, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] res, ta, want;
        logic [4:0] td;
        logic tr;
        int lat, bcnt;
        bit early;
        logic dn;
        for (int i = 0; i < 1000; i++) begin
            ta = 16'($urandom);
            td = 5'($urandom_range(0, 31));
            tr = 1'($urandom);
            want = model(ta, int'(td), tr);
            run_op(ta, td, tr, 1'b1, res, lat, bcnt, early, dn);
            total++;
            if (res !== want || lat !== exp_lat(int'(td)) || early
                || dn !== 1'b0 || bcnt !== exp_lat(int'(td))) begin
                bad++;
                $display("FAIL rand%0d a=%h d=%0d ar=%b r=%h want=%h lat=%0d busy=%0d early=%b",
                         i, ta, td, tr, res, want, lat, bcnt, early);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
